// File: rtl/hex_loader.sv
// rtl/hex_loader.sv - UART hex-text loader that fills HERA command memory, then releases the core
// Optional echo transmitter enabled by defining HEX_LOADER_ECHO_EN.
module hex_loader #(
    parameter int                OVS_DIV  = 1250,
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(16'hEEFF),
    parameter int                RES_LEN  = 4
) (
    input  logic              clk_48,
    input  logic              rst_,
    input  logic              rd,
    input  logic              dtr,
    output logic              dsr,
    output logic              cd,
    input  logic              rts,
    output logic              cts,
    output logic              tx,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    output logic              resout,
    output logic              frame_err
);
    localparam int NIB   = DATA_W / 4;
    localparam int DIV_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int NC_W  = $clog2(NIB + 1);
    localparam int RC_W  = $clog2(RES_LEN + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);
    localparam logic [NC_W-1:0]  NC_LAST  = NC_W'(NIB - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RES_LEN - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
        else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
        else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
        return r;
    endfunction

    logic              rd_s1_q, rd_s2_q;
    logic [2:0]        rx_st_q, rx_st_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              tick;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [NC_W-1:0]   ncnt_q, ncnt_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic              resout_q, resout_d;
    logic [4:0]        hv;
    logic [DATA_W-1:0] word_sh;

    assign dsr       = dtr;
    assign cd        = dtr;
    assign cts       = rts;
    assign data      = data_q;
    assign addr      = addr_q;
    assign wren      = wren_q;
    assign resout    = resout_q;
    assign frame_err = frame_err_q;

    assign hv      = hex_nib(shreg_q);
    assign word_sh = DATA_W'({word_q, hv[3:0]});

    // Start edge is taken on any cycle so the divider can be re-phased to it.
    always_comb begin
        rx_st_d      = rx_st_q;
        tcnt_d       = tcnt_q;
        bcnt_d       = bcnt_q;
        shreg_d      = shreg_q;
        frame_err_d  = frame_err_q;
        byte_valid_d = 1'b0;
        tick         = (div_q == DIV_LAST);
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        case (rx_st_q)
            RX_IDLE: begin
                if (!rd_s2_q) begin
                    rx_st_d = RX_START;
                    div_d   = '0;
                    tcnt_d  = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = 4'd0;
                        bcnt_d  = 3'd0;
                        rx_st_d = rd_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d  = 4'd0;
                        shreg_d = {rd_s2_q, shreg_q[7:1]};
                        if (bcnt_q == 3'd7) rx_st_d = RX_STOP;
                        else                bcnt_d  = bcnt_q + 3'd1;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d = 4'd0;
                        if (rd_s2_q) begin
                            byte_valid_d = 1'b1;
                            rx_st_d      = RX_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            rx_st_d     = RX_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_BREAK: begin
                if (tick && rd_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        ncnt_d   = ncnt_q;
        rcnt_d   = rcnt_q;
        data_d   = data_q;
        resout_d = resout_q;
        wren_d   = 1'b0;
        addr_d   = wren_q ? addr_q + ADDR_W'(1) : addr_q;
        case (state_q)
            ST_LOAD: begin
                if (byte_valid_q) begin
                    if (hv[4]) begin
                        word_d = word_sh;
                        if (ncnt_q == NC_LAST) begin
                            ncnt_d = '0;
                            if (word_sh == END_WORD) begin
                                state_d = ST_RELEASE;
                                rcnt_d  = '0;
                            end else begin
                                data_d = word_sh;
                                wren_d = 1'b1;
                            end
                        end else begin
                            ncnt_d = ncnt_q + NC_W'(1);
                        end
                    end else begin
                        word_d = '0;
                        ncnt_d = '0;
                    end
                end
            end
            ST_RELEASE: begin
                if (rcnt_q == RC_LAST) begin
                    state_d  = ST_DONE;
                    resout_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            ST_DONE: resout_d = 1'b1;
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_48) begin
        if (!rst_) begin
            rd_s1_q      <= 1'b1;
            rd_s2_q      <= 1'b1;
            rx_st_q      <= RX_IDLE;
            div_q        <= '0;
            tcnt_q       <= 4'd0;
            bcnt_q       <= 3'd0;
            shreg_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= ST_LOAD;
            word_q       <= '0;
            ncnt_q       <= '0;
            rcnt_q       <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            wren_q       <= 1'b0;
            resout_q     <= 1'b0;
        end else begin
            rd_s1_q      <= rd;
            rd_s2_q      <= rd_s1_q;
            rx_st_q      <= rx_st_d;
            div_q        <= div_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            word_q       <= word_d;
            ncnt_q       <= ncnt_d;
            rcnt_q       <= rcnt_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            wren_q       <= wren_d;
            resout_q     <= resout_d;
        end
    end

`ifdef HEX_LOADER_ECHO_EN
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic [1:0]       tx_st_q, tx_st_d;
    logic [DIV_W-1:0] tdiv_q, tdiv_d;
    logic [3:0]       ttc_q, ttc_d;
    logic [2:0]       tbit_q, tbit_d;
    logic [7:0]       tsh_q, tsh_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_q, tx_d;
    logic             ttick, take;

    // The holding register may refill in the same cycle the transmitter empties it.
    always_comb begin
        tx_st_d     = tx_st_q;
        ttc_d       = ttc_q;
        tbit_d      = tbit_q;
        tsh_d       = tsh_q;
        hold_d      = hold_q;
        tx_d        = tx_q;
        take        = 1'b0;
        ttick       = (tdiv_q == DIV_LAST);
        tdiv_d      = ttick ? '0 : tdiv_q + DIV_W'(1);
        case (tx_st_q)
            TX_IDLE: begin
                tdiv_d = '0;
                if (hold_full_q) begin
                    take    = 1'b1;
                    tsh_d   = hold_q;
                    tx_d    = 1'b0;
                    ttc_d   = 4'd0;
                    tx_st_d = TX_START;
                end
            end
            TX_START: begin
                if (ttick) begin
                    if (ttc_q == 4'd15) begin
                        ttc_d   = 4'd0;
                        tbit_d  = 3'd0;
                        tx_d    = tsh_q[0];
                        tx_st_d = TX_DATA;
                    end else begin
                        ttc_d = ttc_q + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (ttick) begin
                    if (ttc_q == 4'd15) begin
                        ttc_d = 4'd0;
                        if (tbit_q == 3'd7) begin
                            tx_d    = 1'b1;
                            tx_st_d = TX_STOP;
                        end else begin
                            tbit_d = tbit_q + 3'd1;
                            tsh_d  = {1'b0, tsh_q[7:1]};
                            tx_d   = tsh_q[1];
                        end
                    end else begin
                        ttc_d = ttc_q + 4'd1;
                    end
                end
            end
            default: begin
                if (ttick) begin
                    if (ttc_q == 4'd15) tx_st_d = TX_IDLE;
                    else                ttc_d   = ttc_q + 4'd1;
                end
            end
        endcase
        hold_full_d = hold_full_q & ~take;
        if (byte_valid_q && (!hold_full_q || take)) begin
            hold_d      = shreg_q;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_48) begin
        if (!rst_) begin
            tx_st_q     <= TX_IDLE;
            tdiv_q      <= '0;
            ttc_q       <= 4'd0;
            tbit_q      <= 3'd0;
            tsh_q       <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            tx_st_q     <= tx_st_d;
            tdiv_q      <= tdiv_d;
            ttc_q       <= ttc_d;
            tbit_q      <= tbit_d;
            tsh_q       <= tsh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    assign tx = tx_q;
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_hex_loader.sv
// tb/tb_hex_loader.sv - directed self-checking bench for hex_loader
`timescale 1ns/1ps
module tb_hex_loader;
    localparam int OVS = 4;
    localparam int BIT = 16 * OVS;
    localparam int AW  = 2;
    localparam int RL  = 4;
    // start-bit fall to resout high: 3 cycles sync/detect, 152 ticks to stop sample, then RES_LEN+1
    localparam int RISE_OFS = 3 + 152 * OVS + RL + 1;

    logic          clk_48 = 1'b0;
    logic          rst_ = 1'b0;
    logic          rd = 1'b1;
    logic          dtr = 1'b0;
    logic          rts = 1'b0;
    logic          dsr, cd, cts, tx, wren, resout, frame_err;
    logic [15:0]   data;
    logic [AW-1:0] addr;

    int total = 0;
    int passes = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = -1;
    bit rise_seen = 1'b0;
    bit tx_low_seen = 1'b0;
    logic [AW-1:0] wq_addr[$];
    logic [15:0]   wq_data[$];

    hex_loader #(.OVS_DIV(OVS), .DATA_W(16), .ADDR_W(AW), .END_WORD(16'hEEFF), .RES_LEN(RL)) dut (
        .clk_48(clk_48), .rst_(rst_), .rd(rd), .dtr(dtr), .dsr(dsr), .cd(cd),
        .rts(rts), .cts(cts), .tx(tx), .data(data), .addr(addr), .wren(wren),
        .resout(resout), .frame_err(frame_err)
    );

    always #5 clk_48 = ~clk_48;
    always @(posedge clk_48) cyc++;

    always @(negedge clk_48) begin
        if (wren === 1'b1) begin
            wq_addr.push_back(addr);
            wq_data.push_back(data);
        end
        if (!rst_) rise_seen = 1'b0;
        else if (resout === 1'b1 && !rise_seen) begin
            rise_seen = 1'b1;
            rise_cyc  = cyc;
        end
        if (tx !== 1'b1) tx_low_seen = 1'b1;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
        @(negedge clk_48);
        rd = 1'b0;
        last_start = cyc;
        repeat (BIT) @(negedge clk_48);
        for (int i = 0; i < 8; i++) begin
            rd = b[i];
            repeat (BIT) @(negedge clk_48);
        end
        rd = stop;
        repeat (hold) @(negedge clk_48);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(s.getc(i), 1'b1, BIT);
    endtask

    task automatic do_reset();
        @(negedge clk_48);
        rst_ = 1'b0;
        rd = 1'b1;
        repeat (3) @(negedge clk_48);
        rst_ = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        rise_cyc = -1;
    endtask

    task automatic cap_tx(output logic [7:0] b, output bit ok);
        int n;
        n = 0;
        b = 8'h00;
        ok = 1'b0;
        while (tx !== 1'b0 && n < 40 * BIT) begin
            @(negedge clk_48);
            n++;
        end
        if (tx === 1'b0) begin
            repeat (BIT / 2) @(negedge clk_48);
            ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk_48);
                b[i] = tx;
            end
            repeat (BIT) @(negedge clk_48);
            ok = ok && (tx === 1'b1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        dtr = 1'b1;
        rts = 1'b0;
        @(negedge clk_48);
        total++; if (data !== 16'h0) $display("FAIL reset_data got %h exp 0000", data); else passes++;
        total++; if (addr !== 2'd0) $display("FAIL reset_addr got %0d exp 0", addr); else passes++;
        total++; if (wren !== 1'b0) $display("FAIL reset_wren got %b exp 0", wren); else passes++;
        total++; if (resout !== 1'b0) $display("FAIL reset_resout got %b exp 0", resout); else passes++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else passes++;
        total++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else passes++;
        total++; if ({dsr, cd, cts} !== 3'b110) $display("FAIL modem_pass got %b exp 110", {dsr, cd, cts}); else passes++;
        rts = 1'b1;
        dtr = 1'b0;
        @(negedge clk_48);
        total++; if ({dsr, cd, cts} !== 3'b001) $display("FAIL modem_pass2 got %b exp 001", {dsr, cd, cts}); else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        send_str("12ab");
        total++; if (wq_data.size() != 1) $display("FAIL basic_count got %0d exp 1", wq_data.size()); else passes++;
        total++; if (wq_data.size() > 0 && wq_data[0] !== 16'h12AB) $display("FAIL basic_data got %h exp 12ab", wq_data[0]); else passes++;
        total++; if (wq_addr.size() > 0 && wq_addr[0] !== 2'd0) $display("FAIL basic_waddr got %0d exp 0", wq_addr[0]); else passes++;
        total++; if (addr !== 2'd1) $display("FAIL basic_addr_inc got %0d exp 1", addr); else passes++;
        total++; if (resout !== 1'b0) $display("FAIL basic_resout_load got %b exp 0", resout); else passes++;
        send_str("EEFF");
        total++; if (wq_data.size() != 1) $display("FAIL term_nowrite got %0d exp 1", wq_data.size()); else passes++;
        total++; if (resout !== 1'b1) $display("FAIL term_resout got %b exp 1", resout); else passes++;
        total++; if (rise_cyc - last_start != RISE_OFS) $display("FAIL term_rise_time got %0d exp %0d", rise_cyc - last_start, RISE_OFS); else passes++;
        send_str("1234");
        total++; if (wq_data.size() != 1) $display("FAIL done_ignore got %0d exp 1", wq_data.size()); else passes++;
        total++; if (resout !== 1'b1) $display("FAIL done_resout got %b exp 1", resout); else passes++;
    endtask

    task automatic test_discard();
        do_reset();
        send_str("12 3456");
        total++; if (wq_data.size() != 1) $display("FAIL discard_count got %0d exp 1", wq_data.size()); else passes++;
        total++; if (wq_data.size() > 0 && wq_data[0] !== 16'h3456) $display("FAIL discard_data got %h exp 3456", wq_data[0]); else passes++;
        total++; if (wq_addr.size() > 0 && wq_addr[0] !== 2'd0) $display("FAIL discard_addr got %0d exp 0", wq_addr[0]); else passes++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        send_str("00010002000300040005");
        total++; if (wq_data.size() != 5) $display("FAIL wrap_count got %0d exp 5", wq_data.size()); else passes++;
        if (wq_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                total++; if (wq_addr[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %0d exp %0d", i, wq_addr[i], exp_a[i]); else passes++;
                total++; if (wq_data[i] !== 16'(i + 1)) $display("FAIL wrap_data%0d got %h exp %h", i, wq_data[i], 16'(i + 1)); else passes++;
            end
        end
    endtask

    task automatic test_glitch_frame();
        do_reset();
        send_str("12");
        @(negedge clk_48);
        rd = 1'b0;
        repeat (5 * OVS) @(negedge clk_48);
        rd = 1'b1;
        repeat (2 * BIT) @(negedge clk_48);
        total++; if (frame_err !== 1'b0) $display("FAIL glitch_ferr got %b exp 0", frame_err); else passes++;
        send_str("34");
        total++; if (wq_data.size() != 1) $display("FAIL glitch_count got %0d exp 1", wq_data.size()); else passes++;
        total++; if (wq_data.size() > 0 && wq_data[0] !== 16'h1234) $display("FAIL glitch_data got %h exp 1234", wq_data[0]); else passes++;
        send_frame(8'h39, 1'b0, 3 * BIT);
        rd = 1'b1;
        repeat (BIT) @(negedge clk_48);
        total++; if (frame_err !== 1'b1) $display("FAIL badstop_ferr got %b exp 1", frame_err); else passes++;
        send_str("1234");
        total++; if (wq_data.size() != 2) $display("FAIL badstop_count got %0d exp 2", wq_data.size()); else passes++;
        total++; if (wq_data.size() > 1 && wq_data[1] !== 16'h1234) $display("FAIL badstop_data got %h exp 1234", wq_data[1]); else passes++;
        total++; if (wq_addr.size() > 1 && wq_addr[1] !== 2'd1) $display("FAIL badstop_addr got %0d exp 1", wq_addr[1]); else passes++;
        total++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky got %b exp 1", frame_err); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_str("5678");
        send_str("12");
        rst_ = 1'b0;
        @(negedge clk_48);
        total++; if (data !== 16'h0) $display("FAIL midword_data got %h exp 0000", data); else passes++;
        total++; if (addr !== 2'd0) $display("FAIL midword_addr got %0d exp 0", addr); else passes++;
        rst_ = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        send_str("00FF");
        total++; if (wq_data.size() != 1) $display("FAIL after_rst_count got %0d exp 1", wq_data.size()); else passes++;
        total++; if (wq_data.size() > 0 && wq_data[0] !== 16'h00FF) $display("FAIL after_rst_data got %h exp 00ff", wq_data[0]); else passes++;
        total++; if (wq_addr.size() > 0 && wq_addr[0] !== 2'd0) $display("FAIL after_rst_addr got %0d exp 0", wq_addr[0]); else passes++;
        send_str("EEF");
        // cut the final stop bit short so reset lands two cycles into RELEASE
        send_frame(8'h46, 1'b1, 37);
        rst_ = 1'b0;
        @(negedge clk_48);
        total++; if (addr !== 2'd0) $display("FAIL midrel_addr got %0d exp 0", addr); else passes++;
        total++; if (data !== 16'h0) $display("FAIL midrel_data got %h exp 0000", data); else passes++;
        rst_ = 1'b1;
        repeat (40) @(negedge clk_48);
        total++; if (resout !== 1'b0) $display("FAIL midrel_resout got %b exp 0", resout); else passes++;
    endtask

    task automatic test_echo();
        logic [7:0] b0, b1;
        bit ok0, ok1;
        do_reset();
`ifdef HEX_LOADER_ECHO_EN
        fork
            send_str("A5");
            begin
                cap_tx(b0, ok0);
                cap_tx(b1, ok1);
            end
        join
        total++; if (b0 !== 8'h41 || !ok0) $display("FAIL echo0 got %h/%b exp 41/1", b0, ok0); else passes++;
        total++; if (b1 !== 8'h35 || !ok1) $display("FAIL echo1 got %h/%b exp 35/1", b1, ok1); else passes++;
`else
        b0 = 8'h00; b1 = 8'h00; ok0 = 1'b0; ok1 = 1'b0;
        tx_low_seen = 1'b0;
        send_str("A5");
        total++; if (tx_low_seen !== 1'b0) $display("FAIL noecho_tx got low exp constant 1"); else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_discard();
        test_wrap();
        test_glitch_frame();
        test_reset_mid();
        test_echo();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
